instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

- Instruction-fetch front end that drives the word address into the instruction memory and registers the returned instruction into the IF/ID pipeline register.
- Holds the program counter, sequences it by +4, and honours pipeline stalls and taken-branch/jump redirects with flush.
- Traps fetches beyond the populated memory depth.
- Sits between the instruction memory (asynchronous, combinational read indexed by Address[11:2]) and the decode stage.

## Interface

Parameters:
- MEM_WORDS, 396, number of populated instruction words; a fetch with Address[31:2] >= MEM_WORDS is out of range.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hold PC and IF/ID outputs (hazard unit).
- Flush  in  1  taken branch/jump from decode; redirect PC and squash the IF/ID slot.
- TargetAddress  in  32  redirect target, sampled only when Flush=1.
- Instruction  in  32  word returned combinationally by instruction memory for Address.
- Address  out  32  byte address to instruction memory; equals the PC register.
- IF_Instruction  out  32  registered instruction to decode.
- IF_PCPlus4  out  32  registered PC+4 of IF_Instruction.
- IF_Valid  out  1  IF_Instruction is a real fetched instruction.
- Fault  out  1  sticky out-of-range fetch flag.
- FetchCount  out  32  count of instructions captured with IF_Valid=1; wraps modulo 2^32.

## Operation

States: INIT, RUN, FAULT.

- **Reset (Reset=0, asynchronous):**
  - State=INIT, PC=RESET_PC.
  - IF_Instruction=0, IF_PCPlus4=0, IF_Valid=0, Fault=0, FetchCount=0.
- **INIT:** at the first edge after reset release, go to RUN with no capture. PC is unchanged and IF_Valid stays 0.
- **RUN, evaluated per edge in strict priority order:**
  1. Flush=1:
     - PC <= {TargetAddress[31:2], 2'b00}; misaligned low bits are discarded.
     - IF_Instruction <= 0 (NOP), IF_Valid <= 0, IF_PCPlus4 unchanged.
     - Flush wins over Stall.
  2. Stall=1: PC and all IF outputs hold; FetchCount holds.
  3. PC[31:2] >= MEM_WORDS:
     - State <= FAULT, Fault <= 1.
     - IF_Instruction <= 0, IF_Valid <= 0.
     - PC holds; no capture.
  4. Otherwise:
     - IF_Instruction <= Instruction, IF_PCPlus4 <= PC+4, IF_Valid <= 1.
     - PC <= PC+4, FetchCount <= FetchCount+1.
- **FAULT:**
  - IF_Valid=0, IF_Instruction=0, PC holds; Stall is ignored.
  - Flush with an in-range target: PC <= aligned target, state <= RUN, Fault stays 1 (sticky until reset).
  - Flush with an out-of-range target: stay in FAULT with the PC loaded.
- **Arithmetic:** PC+4 is a 32-bit add and wraps at 2^32. The out-of-range check uses PC[31:2] compared unsigned against MEM_WORDS.

## Timing

- Address is a direct register output: it changes only after a rising edge (or on asynchronous reset), with no combinational path from any input.
- Fetch latency: the instruction at PC appears on IF_Instruction one cycle after PC is presented on Address.
- Sustained throughput: one instruction per cycle when Stall=0 and Flush=0.
- Redirect:
  - The target word appears on Address the cycle after the Flush edge.
  - The first valid instruction from the target appears on IF_Instruction two edges after Flush.
  - Exactly one bubble (IF_Valid=0) follows each Flush.
- Stall and Flush are sampled on the same edge; Flush dominates and the stall is dropped for that edge.
- Reset asserted mid-fetch: all outputs take their reset values immediately, independent of Clk.

## Test plan

- **Reset and sequential fetch:** memory word k = 32'h1000_0000+k; hold Reset=0 for 3 cycles, then release.
  - Address=0 through INIT.
  - IF_Instruction = 32'h1000_0000, 32'h1000_0001, ... on successive edges, with IF_PCPlus4=4,8,... and IF_Valid=1.
  - FetchCount increments by 1 per edge.
- **Stall:** assert Stall for 3 cycles at PC=0x10.
  - Address stays 0x10; IF_Instruction stays at word 3; FetchCount is frozen.
  - After release, word 4 appears on the next edge.
- **Flush overrides stall:** Stall=1 and Flush=1 with TargetAddress=0x43 on the same edge.
  - Next cycle: Address=0x40, IF_Valid=0, IF_Instruction=0.
  - Following edge: IF_Instruction=word 16, IF_PCPlus4=0x44.
- **Out-of-range fault:** run to PC=0x62C (word 395), then PC=0x630.
  - Word 395 is captured normally.
  - At 0x630: Fault=1, IF_Valid=0, PC holds 0x630.
  - Flush to 0x8: fetch resumes at word 2 and Fault remains 1.
- **Asynchronous reset mid-run:** pulse Reset low for less than one clock period while PC=0x24.
  - Address=0, IF_Valid=0, Fault=0, FetchCount=0 immediately, without a clock edge.
  - Sequence restarts from word 0 after INIT.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction-fetch front end: PC sequencing, stall/flush redirect, IF/ID register
// and a sticky trap for fetches past the populated instruction memory.
module instruction_fetch_unit #(
   parameter int unsigned MEM_WORDS = 396,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic [31:0] TargetAddress,
   input  logic [31:0] Instruction,
   output logic [31:0] Address,
   output logic [31:0] IF_Instruction,
   output logic [31:0] IF_PCPlus4,
   output logic        IF_Valid,
   output logic        Fault,
   output logic [31:0] FetchCount
);

   localparam logic [31:0] MEM_LIMIT = MEM_WORDS;

   typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc4_q, if_pc4_d;
   logic        if_valid_q, if_valid_d;
   logic        fault_q, fault_d;
   logic [31:0] fetch_count_q, fetch_count_d;

   logic [31:0] target_aligned;
   logic        pc_out_of_range;
   logic        target_out_of_range;

   always_comb begin
      target_aligned      = {TargetAddress[31:2], 2'b00};
      pc_out_of_range     = {2'b00, pc_q[31:2]} >= MEM_LIMIT;
      target_out_of_range = {2'b00, target_aligned[31:2]} >= MEM_LIMIT;
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_instr_d    = if_instr_q;
      if_pc4_d      = if_pc4_q;
      if_valid_d    = if_valid_q;
      fault_d       = fault_q;
      fetch_count_d = fetch_count_q;
      unique case (state_q)
         INIT: state_d = RUN;
         RUN: begin
            if (Flush) begin
               // Redirect squashes the slot; IF_PCPlus4 keeps its old value.
               pc_d       = target_aligned;
               if_instr_d = 32'h0;
               if_valid_d = 1'b0;
            end else if (Stall) begin
               state_d = RUN;
            end else if (pc_out_of_range) begin
               state_d    = FAULT;
               fault_d    = 1'b1;
               if_instr_d = 32'h0;
               if_valid_d = 1'b0;
            end else begin
               if_instr_d    = Instruction;
               if_pc4_d      = pc_q + 32'd4;
               if_valid_d    = 1'b1;
               pc_d          = pc_q + 32'd4;
               fetch_count_d = fetch_count_q + 32'd1;
            end
         end
         FAULT: begin
            // Stall is ignored here; only a redirect can leave the trap.
            if_instr_d = 32'h0;
            if_valid_d = 1'b0;
            if (Flush) begin
               pc_d = target_aligned;
               if (!target_out_of_range) state_d = RUN;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q       <= INIT;
         pc_q          <= RESET_PC;
         if_instr_q    <= 32'h0;
         if_pc4_q      <= 32'h0;
         if_valid_q    <= 1'b0;
         fault_q       <= 1'b0;
         fetch_count_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_instr_q    <= if_instr_d;
         if_pc4_q      <= if_pc4_d;
         if_valid_q    <= if_valid_d;
         fault_q       <= fault_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign Address        = pc_q;
   assign IF_Instruction = if_instr_q;
   assign IF_PCPlus4     = if_pc4_q;
   assign IF_Valid       = if_valid_q;
   assign Fault          = fault_q;
   assign FetchCount     = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory word k holds 32'h1000_0000 + k.
module tb_instruction_fetch_unit;

   logic        Clk;
   logic        Reset;
   logic        Stall;
   logic        Flush;
   logic [31:0] TargetAddress;
   logic [31:0] Instruction;
   logic [31:0] Address;
   logic [31:0] IF_Instruction;
   logic [31:0] IF_PCPlus4;
   logic        IF_Valid;
   logic        Fault;
   logic [31:0] FetchCount;

   int vectors = 0;
   int errors  = 0;

   instruction_fetch_unit #(.MEM_WORDS(396), .RESET_PC(32'h0000_0000)) dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
      .TargetAddress(TargetAddress), .Instruction(Instruction),
      .Address(Address), .IF_Instruction(IF_Instruction), .IF_PCPlus4(IF_PCPlus4),
      .IF_Valid(IF_Valid), .Fault(Fault), .FetchCount(FetchCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   assign Instruction = 32'h1000_0000 + {22'h0, Address[11:2]};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_fetch(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                            input logic [31:0] addr, input logic [31:0] cnt);
      chk({tag, ".instr"}, IF_Instruction, instr);
      chk({tag, ".pc4"}, IF_PCPlus4, pc4);
      chk({tag, ".valid"}, {31'h0, IF_Valid}, 32'h1);
      chk({tag, ".addr"}, Address, addr);
      chk({tag, ".count"}, FetchCount, cnt);
   endtask

   initial begin
      Reset = 1'b0; Stall = 1'b0; Flush = 1'b0; TargetAddress = 32'h0;
      repeat (3) step();
      chk("rst.addr", Address, 32'h0);
      chk("rst.instr", IF_Instruction, 32'h0);
      chk("rst.pc4", IF_PCPlus4, 32'h0);
      chk("rst.valid", {31'h0, IF_Valid}, 32'h0);
      chk("rst.fault", {31'h0, Fault}, 32'h0);
      chk("rst.count", FetchCount, 32'h0);

      Reset = 1'b1;
      step();
      chk("init.addr", Address, 32'h0);
      chk("init.valid", {31'h0, IF_Valid}, 32'h0);
      chk("init.count", FetchCount, 32'h0);

      step(); chk_fetch("seq0", 32'h1000_0000, 32'h4, 32'h4, 32'd1);
      step(); chk_fetch("seq1", 32'h1000_0001, 32'h8, 32'h8, 32'd2);
      step(); chk_fetch("seq2", 32'h1000_0002, 32'hC, 32'hC, 32'd3);
      step(); chk_fetch("seq3", 32'h1000_0003, 32'h10, 32'h10, 32'd4);

      // Stall three cycles at PC=0x10
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); chk_fetch("stall", 32'h1000_0003, 32'h10, 32'h10, 32'd4);
      end
      Stall = 1'b0;
      step(); chk_fetch("unstall", 32'h1000_0004, 32'h14, 32'h14, 32'd5);

      // Flush dominates a simultaneous stall; misaligned target rounded down
      Stall = 1'b1; Flush = 1'b1; TargetAddress = 32'h43;
      step();
      Stall = 1'b0; Flush = 1'b0;
      chk("flush.addr", Address, 32'h40);
      chk("flush.valid", {31'h0, IF_Valid}, 32'h0);
      chk("flush.instr", IF_Instruction, 32'h0);
      chk("flush.pc4", IF_PCPlus4, 32'h14);
      chk("flush.count", FetchCount, 32'd5);
      step(); chk_fetch("redir", 32'h1000_0010, 32'h44, 32'h44, 32'd6);

      // Run to the last populated word
      Flush = 1'b1; TargetAddress = 32'h62C;
      step();
      Flush = 1'b0;
      chk("jmp395.addr", Address, 32'h62C);
      step(); chk_fetch("w395", 32'h1000_018B, 32'h630, 32'h630, 32'd7);
      chk("w395.fault", {31'h0, Fault}, 32'h0);
      step();
      chk("oor.fault", {31'h0, Fault}, 32'h1);
      chk("oor.valid", {31'h0, IF_Valid}, 32'h0);
      chk("oor.instr", IF_Instruction, 32'h0);
      chk("oor.addr", Address, 32'h630);
      chk("oor.count", FetchCount, 32'd7);
      Stall = 1'b1;
      step();
      Stall = 1'b0;
      chk("oor.hold", Address, 32'h630);

      // Out-of-range redirect stays trapped
      Flush = 1'b1; TargetAddress = 32'h700;
      step();
      Flush = 1'b0;
      chk("oor2.addr", Address, 32'h700);
      step();
      chk("oor2.hold", Address, 32'h700);
      chk("oor2.valid", {31'h0, IF_Valid}, 32'h0);

      Flush = 1'b1; TargetAddress = 32'h8;
      step();
      Flush = 1'b0;
      chk("resume.addr", Address, 32'h8);
      chk("resume.valid", {31'h0, IF_Valid}, 32'h0);
      step(); chk_fetch("resume", 32'h1000_0002, 32'hC, 32'hC, 32'd8);
      chk("resume.fault", {31'h0, Fault}, 32'h1);

      for (int i = 0; i < 6; i++) step();
      chk("pre_rst.addr", Address, 32'h24);
      chk("pre_rst.count", FetchCount, 32'd14);

      // Short asynchronous reset pulse between edges
      #2 Reset = 1'b0;
      #1;
      chk("arst.addr", Address, 32'h0);
      chk("arst.valid", {31'h0, IF_Valid}, 32'h0);
      chk("arst.fault", {31'h0, Fault}, 32'h0);
      chk("arst.count", FetchCount, 32'h0);
      chk("arst.instr", IF_Instruction, 32'h0);
      #2 Reset = 1'b1;
      step();
      chk("reinit.addr", Address, 32'h0);
      chk("reinit.valid", {31'h0, IF_Valid}, 32'h0);
      step(); chk_fetch("restart", 32'h1000_0000, 32'h4, 32'h4, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
